// File: rtl/trig_pulse_arbiter.sv
// Round-robin arbiter sharing one stretched trigger line among NREQ sources.
// Define TRIG_ARB_PENDING_EN to hold edges that arrive while busy.
module trig_pulse_arbiter #(
    parameter int NREQ     = 4,
    parameter int LEN_BITS = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NREQ-1:0]     req_i,
    input  logic [NREQ-1:0]     enable_i,
    input  logic [LEN_BITS-1:0] stretch_len_i,
    input  logic [LEN_BITS-1:0] holdoff_len_i,
    output logic                trig_out_o,
    output logic [NREQ-1:0]     trig_id_o,
    output logic                busy_o,
    output logic [15:0]         lost_count_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_HOLD
    } state_t;

    state_t              state_q;
    logic [LEN_BITS-1:0] cnt_q;
    logic [LEN_BITS-1:0] hold_q;
    logic [PW-1:0]       ptr_q;
    logic [PW-1:0]       ptr_d;
    logic [NREQ-1:0]     req_q;
    logic [NREQ-1:0]     edge_w;
    logic [NREQ-1:0]     cand_w;
    logic [NREQ-1:0]     gnt_w;
    logic [NREQ-1:0]     lost_w;
    logic [NREQ-1:0]     id_q;
    logic [15:0]         lost_q;
    logic [15:0]         lost_d;
    logic [16:0]         lost_sum;
    logic                trig_q;
    logic                busy_q;
    logic                any_gnt;
    int                  idx;

    assign edge_w = req_i & ~req_q & enable_i;

`ifdef TRIG_ARB_PENDING_EN
    logic [NREQ-1:0] pend_q;
    logic [NREQ-1:0] pend_d;

    always_comb begin
        cand_w = pend_q | edge_w;
        // An edge is only dropped when its source already has one queued.
        lost_w = edge_w & pend_q & ~gnt_w;
        pend_d = (pend_q | edge_w) & ~gnt_w & enable_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end
`else
    always_comb begin
        cand_w = edge_w;
        lost_w = edge_w & ~gnt_w;
    end
`endif

    // First candidate at ptr, ptr+1, ... wrapping at NREQ.
    always_comb begin
        gnt_w   = '0;
        ptr_d   = ptr_q;
        any_gnt = 1'b0;
        idx     = 0;
        if (state_q == S_IDLE) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= NREQ) begin
                    idx = idx - NREQ;
                end
                if (!any_gnt && cand_w[idx]) begin
                    any_gnt    = 1'b1;
                    gnt_w[idx] = 1'b1;
                    ptr_d      = (idx == NREQ - 1) ? '0 : PW'(idx + 1);
                end
            end
        end
    end

    always_comb begin
        lost_sum = {1'b0, lost_q};
        for (int i = 0; i < NREQ; i++) begin
            lost_sum = lost_sum + 17'(lost_w[i]);
        end
        lost_d = lost_sum[16] ? 16'hFFFF : lost_sum[15:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_q  <= '0;
            lost_q <= '0;
        end else begin
            req_q  <= req_i;
            lost_q <= lost_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            ptr_q   <= '0;
            id_q    <= '0;
            trig_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (any_gnt) begin
                        state_q <= S_PULSE;
                        trig_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        id_q    <= gnt_w;
                        ptr_q   <= ptr_d;
                        hold_q  <= holdoff_len_i;
                        // cnt_q holds cycles remaining after the current one.
                        cnt_q   <= (stretch_len_i == '0) ? '0
                                 : stretch_len_i - LEN_BITS'(1);
                    end
                end
                S_PULSE: begin
                    if (cnt_q == '0) begin
                        trig_q <= 1'b0;
                        if (hold_q == '0) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_HOLD;
                            cnt_q   <= hold_q - LEN_BITS'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q - LEN_BITS'(1);
                    end
                end
                S_HOLD: begin
                    if (cnt_q == '0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - LEN_BITS'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    trig_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign trig_out_o   = trig_q;
    assign trig_id_o    = id_q;
    assign busy_o       = busy_q;
    assign lost_count_o = lost_q;

endmodule

// File: tb/tb_trig_pulse_arbiter.sv
// Directed bench for trig_pulse_arbiter: per-cycle vector table plus
// hand-written multi-cycle sequences (arbitration, fairness, saturation).
module tb_trig_pulse_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [3:0]  en = 4'hF;
    logic [7:0]  sl = 8'd5;
    logic [7:0]  hl = 8'd3;
    logic        trig;
    logic [3:0]  trig_id;
    logic        busy;
    logic [15:0] lost;

    int n_cmp = 0;
    int n_bad = 0;
    int pulses = 0;
    logic [3:0] ids[$];
    logic prev_trig = 1'b0;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  en;
        logic [7:0]  sl;
        logic [7:0]  hl;
        logic        trig;
        logic        busy;
        logic [3:0]  id;
        logic [15:0] lost;
    } vec_t;

    vec_t tbl[$];

    trig_pulse_arbiter #(.NREQ(4), .LEN_BITS(8)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_i         (req),
        .enable_i      (en),
        .stretch_len_i (sl),
        .holdoff_len_i (hl),
        .trig_out_o    (trig),
        .trig_id_o     (trig_id),
        .busy_o        (busy),
        .lost_count_o  (lost)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(logic [3:0] r);
        @(negedge clk);
        req = r;
        @(posedge clk);
        #1;
        if (trig && !prev_trig) begin
            pulses++;
            ids.push_back(trig_id);
        end
        prev_trig = trig;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        prev_trig = 1'b0;
        pulses = 0;
        ids.delete();
    endtask

    initial begin
        // req, en, stretch, holdoff, trig, busy, id, lost
        tbl.push_back('{4'h0, 4'hF, 8'd5, 8'd3, 1'b0, 1'b0, 4'h0, 16'd0});
        tbl.push_back('{4'h4, 4'hF, 8'd5, 8'd3, 1'b1, 1'b1, 4'h4, 16'd0});
        tbl.push_back('{4'h4, 4'hF, 8'd9, 8'd3, 1'b1, 1'b1, 4'h4, 16'd0});
        tbl.push_back('{4'h4, 4'hF, 8'd9, 8'd3, 1'b1, 1'b1, 4'h4, 16'd0});
        tbl.push_back('{4'h0, 4'hF, 8'd5, 8'd3, 1'b1, 1'b1, 4'h4, 16'd0});
        tbl.push_back('{4'h0, 4'hF, 8'd5, 8'd3, 1'b1, 1'b1, 4'h4, 16'd0});
        tbl.push_back('{4'h0, 4'hF, 8'd5, 8'd3, 1'b0, 1'b1, 4'h4, 16'd0});
        tbl.push_back('{4'h0, 4'hF, 8'd5, 8'd3, 1'b0, 1'b1, 4'h4, 16'd0});
        tbl.push_back('{4'h0, 4'hF, 8'd5, 8'd3, 1'b0, 1'b1, 4'h4, 16'd0});
        tbl.push_back('{4'h0, 4'hF, 8'd5, 8'd3, 1'b0, 1'b0, 4'h4, 16'd0});
        tbl.push_back('{4'h1, 4'hF, 8'd0, 8'd0, 1'b1, 1'b1, 4'h1, 16'd0});
        tbl.push_back('{4'h1, 4'hF, 8'd0, 8'd0, 1'b0, 1'b0, 4'h1, 16'd0});
        tbl.push_back('{4'h0, 4'hF, 8'd0, 8'd0, 1'b0, 1'b0, 4'h1, 16'd0});
        tbl.push_back('{4'h4, 4'hB, 8'd0, 8'd0, 1'b0, 1'b0, 4'h1, 16'd0});
        tbl.push_back('{4'h0, 4'hB, 8'd0, 8'd0, 1'b0, 1'b0, 4'h1, 16'd0});
        tbl.push_back('{4'h4, 4'hB, 8'd0, 8'd0, 1'b0, 1'b0, 4'h1, 16'd0});
        tbl.push_back('{4'h0, 4'hB, 8'd0, 8'd0, 1'b0, 1'b0, 4'h1, 16'd0});

        do_reset();
        check("rst_trig", 32'(trig), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_id", 32'(trig_id), 0);
        check("rst_lost", 32'(lost), 0);

        foreach (tbl[i]) begin
            en = tbl[i].en;
            sl = tbl[i].sl;
            hl = tbl[i].hl;
            step(tbl[i].req);
            check($sformatf("v%0d_trig", i), 32'(trig), 32'(tbl[i].trig));
            check($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            check($sformatf("v%0d_id", i), 32'(trig_id), 32'(tbl[i].id));
            check($sformatf("v%0d_lost", i), 32'(lost), 32'(tbl[i].lost));
        end

        // Four simultaneous edges from IDLE.
        en = 4'hF;
        sl = 8'd2;
        hl = 8'd1;
        do_reset();
        for (int c = 0; c < 31; c++) step(4'hF);
`ifdef TRIG_ARB_PENDING_EN
        check("simul_pulses", 32'(pulses), 4);
        check("simul_id0", 32'(ids[0]), 32'h1);
        check("simul_id1", 32'(ids[1]), 32'h2);
        check("simul_id2", 32'(ids[2]), 32'h4);
        check("simul_id3", 32'(ids[3]), 32'h8);
        check("simul_lost", 32'(lost), 0);
`else
        check("simul_pulses", 32'(pulses), 1);
        check("simul_id0", 32'(ids[0]), 32'h1);
        check("simul_lost", 32'(lost), 3);
`endif

        // Sources 1 and 3 re-edge while the block is busy.
        sl = 8'd1;
        hl = 8'd4;
        do_reset();
        for (int c = 0; c < 30; c++) begin
            step((c == 0 || c % 6 == 3) ? 4'hA : 4'h0);
        end
        check("fair_id0", 32'(ids[0]), 32'h2);
        check("fair_id1", 32'(ids[1]), 32'h8);
        check("fair_id2", 32'(ids[2]), 32'h2);
        check("fair_id3", 32'(ids[3]), 32'h8);
`ifdef TRIG_ARB_PENDING_EN
        check("fair_lost", 32'(lost), 5);
`else
        check("fair_lost", 32'(lost), 7);
`endif

        // Level-held request counts once.
        sl = 8'd2;
        hl = 8'd0;
        do_reset();
        step(4'h0);
        for (int c = 0; c < 50; c++) step(4'h2);
        for (int c = 0; c < 5; c++) step(4'h0);
        check("level_pulses", 32'(pulses), 1);
        check("level_id", 32'(ids[0]), 32'h2);
        check("level_lost", 32'(lost), 0);

        // Saturate the lost counter.
        sl = 8'd255;
        hl = 8'd255;
        do_reset();
        for (int c = 0; c < 20000; c++) begin
            step(4'hF);
            step(4'h0);
        end
        check("sat_lost", 32'(lost), 32'hFFFF);
        begin
            int w;
            w = 0;
            while (busy && w < 5000) begin
                step(4'h0);
                w++;
            end
        end
        check("drain_busy", 32'(busy), 0);
        check("sat_hold", 32'(lost), 32'hFFFF);

        // Asynchronous reset in the middle of a pulse.
        sl = 8'd10;
        hl = 8'd0;
        step(4'h1);
        step(4'h1);
        step(4'h1);
        check("pre_rst_trig", 32'(trig), 1);
        check("pre_rst_id", 32'(trig_id), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("async_trig", 32'(trig), 0);
        check("async_busy", 32'(busy), 0);
        check("async_id", 32'(trig_id), 0);
        check("async_lost", 32'(lost), 0);
        @(negedge clk);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
